// File: rtl/axi_tester_pkg.sv
// Shared types and constants for the single-beat AXI bring-up tester.
package axi_tester_pkg;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_WRITE,
      ST_WRESP,
      ST_READ,
      ST_RRESP,
      ST_DONE
   } tester_state_e;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;

   // AXI size field: log2 of bytes per beat.
   function automatic logic [2:0] size_enc(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi_bus_if.sv
// AXI4 bus interface (AW/W/B/AR/R) with Master and Slave modports.
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 5,
   parameter int unsigned AXI_USER_WIDTH = 64
);
   localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]                aw_len;
   logic [2:0]                aw_size;
   logic [1:0]                aw_burst;
   logic                      aw_lock;
   logic [3:0]                aw_cache;
   logic [2:0]                aw_prot;
   logic [3:0]                aw_qos;
   logic [3:0]                aw_region;
   logic [5:0]                aw_atop;
   logic [AXI_USER_WIDTH-1:0] aw_user;
   logic                      aw_valid;
   logic                      aw_ready;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0]     w_strb;
   logic                      w_last;
   logic [AXI_USER_WIDTH-1:0] w_user;
   logic                      w_valid;
   logic                      w_ready;

   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic [AXI_USER_WIDTH-1:0] b_user;
   logic                      b_valid;
   logic                      b_ready;

   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]                ar_len;
   logic [2:0]                ar_size;
   logic [1:0]                ar_burst;
   logic                      ar_lock;
   logic [3:0]                ar_cache;
   logic [2:0]                ar_prot;
   logic [3:0]                ar_qos;
   logic [3:0]                ar_region;
   logic [AXI_USER_WIDTH-1:0] ar_user;
   logic                      ar_valid;
   logic                      ar_ready;

   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_USER_WIDTH-1:0] r_user;
   logic                      r_valid;
   logic                      r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_atop, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_atop, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/axi_single_beat_tester.sv
// Bring-up traffic generator: one-beat write of DATA to ADDRESS, read-back,
// then sticky done/error flags and the captured read data.
module axi_single_beat_tester
   import axi_tester_pkg::*;
#(
   parameter int unsigned              AXI_ID_WIDTH   = 5,
   parameter int unsigned              AXI_ADDR_WIDTH = 64,
   parameter int unsigned              AXI_DATA_WIDTH = 64,
   parameter int unsigned              AXI_USER_WIDTH = 64,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDRESS       = 'h9000_0004,
   parameter logic [AXI_DATA_WIDTH-1:0] DATA          = 'hABCD,
   parameter int unsigned              START_DELAY    = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   AXI_BUS.Master                    axi_master_port,
   output logic                      done_o,
   output logic                      error_o,
   output logic [AXI_DATA_WIDTH-1:0] rdata_o
);

   localparam logic [2:0] SIZE = size_enc(AXI_DATA_WIDTH);

   tester_state_e             r_state;
   logic [31:0]               r_cnt;
   logic                      r_aw_valid;
   logic                      r_w_valid;
   logic                      r_aw_done;
   logic                      r_w_done;
   logic                      r_b_ready;
   logic                      r_ar_valid;
   logic                      r_r_ready;
   logic                      r_done;
   logic                      r_error;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;

   logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic w_unused;

   assign w_aw_hs  = r_aw_valid && axi_master_port.aw_ready;
   assign w_w_hs   = r_w_valid  && axi_master_port.w_ready;
   assign w_b_hs   = r_b_ready  && axi_master_port.b_valid;
   assign w_ar_hs  = r_ar_valid && axi_master_port.ar_ready;
   assign w_r_hs   = r_r_ready  && axi_master_port.r_valid;
   assign w_unused = ^{axi_master_port.b_id, axi_master_port.b_user,
                       axi_master_port.r_id, axi_master_port.r_user};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_WAIT;
         r_cnt      <= '0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_b_ready  <= 1'b0;
         r_ar_valid <= 1'b0;
         r_r_ready  <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (r_cnt == START_DELAY) begin
                  r_state    <= ST_WRITE;
                  r_aw_valid <= 1'b1;
                  r_w_valid  <= 1'b1;
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_WRITE: begin
               // AW and W may be accepted in either order; leave once both are in.
               if (w_aw_hs) begin
                  r_aw_valid <= 1'b0;
                  r_aw_done  <= 1'b1;
               end
               if (w_w_hs) begin
                  r_w_valid <= 1'b0;
                  r_w_done  <= 1'b1;
               end
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                  r_state   <= ST_WRESP;
                  r_b_ready <= 1'b1;
               end
            end
            ST_WRESP: begin
               if (w_b_hs) begin
                  r_b_ready  <= 1'b0;
                  r_ar_valid <= 1'b1;
                  r_state    <= ST_READ;
                  if (axi_master_port.b_resp != RESP_OKAY) r_error <= 1'b1;
               end
            end
            ST_READ: begin
               if (w_ar_hs) begin
                  r_ar_valid <= 1'b0;
                  r_r_ready  <= 1'b1;
                  r_state    <= ST_RRESP;
               end
            end
            ST_RRESP: begin
               if (w_r_hs) begin
                  r_r_ready <= 1'b0;
                  r_rdata   <= axi_master_port.r_data;
                  r_done    <= 1'b1;
                  r_state   <= ST_DONE;
                  if (axi_master_port.r_resp != RESP_OKAY ||
                      axi_master_port.r_data != DATA ||
                      !axi_master_port.r_last) r_error <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_WAIT;
         endcase
      end
   end

   assign axi_master_port.aw_id     = '0;
   assign axi_master_port.aw_addr   = ADDRESS;
   assign axi_master_port.aw_len    = '0;
   assign axi_master_port.aw_size   = SIZE;
   assign axi_master_port.aw_burst  = BURST_INCR;
   assign axi_master_port.aw_lock   = 1'b0;
   assign axi_master_port.aw_cache  = '0;
   assign axi_master_port.aw_prot   = '0;
   assign axi_master_port.aw_qos    = '0;
   assign axi_master_port.aw_region = '0;
   assign axi_master_port.aw_atop   = '0;
   assign axi_master_port.aw_user   = '0;
   assign axi_master_port.aw_valid  = r_aw_valid;

   assign axi_master_port.w_data    = DATA;
   assign axi_master_port.w_strb    = '1;
   assign axi_master_port.w_last    = 1'b1;
   assign axi_master_port.w_user    = '0;
   assign axi_master_port.w_valid   = r_w_valid;

   assign axi_master_port.b_ready   = r_b_ready;

   assign axi_master_port.ar_id     = '0;
   assign axi_master_port.ar_addr   = ADDRESS;
   assign axi_master_port.ar_len    = '0;
   assign axi_master_port.ar_size   = SIZE;
   assign axi_master_port.ar_burst  = BURST_INCR;
   assign axi_master_port.ar_lock   = 1'b0;
   assign axi_master_port.ar_cache  = '0;
   assign axi_master_port.ar_prot   = '0;
   assign axi_master_port.ar_qos    = '0;
   assign axi_master_port.ar_region = '0;
   assign axi_master_port.ar_user   = '0;
   assign axi_master_port.ar_valid  = r_ar_valid;

   assign axi_master_port.r_ready   = r_r_ready;

   assign done_o  = r_done;
   assign error_o = r_error;
   assign rdata_o = r_rdata;

endmodule

// File: tb/tb_axi_single_beat_tester.sv
// Scoreboard bench: memory-like slave with programmable stalls/responses,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_axi_single_beat_tester;

   localparam int unsigned IW = 5, AW = 64, DW = 64, UW = 64;
   localparam logic [AW-1:0] ADDR  = 64'h9000_0004;
   localparam logic [DW-1:0] WDATA = 64'hABCD;
   localparam int SD = 10;

   typedef struct {
      int          lat;
      logic [63:0] rdata;
      logic        err;
      int          start;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          done, err, done0, err0;
   logic [DW-1:0] rdata, rdata0;

   AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi ();
   AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi0 ();

   axi_single_beat_tester #(
      .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
      .ADDRESS(ADDR), .DATA(WDATA), .START_DELAY(SD)
   ) dut (
      .clk_i(clk), .rst_i(rst), .axi_master_port(axi),
      .done_o(done), .error_o(err), .rdata_o(rdata)
   );

   axi_single_beat_tester #(
      .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
      .ADDRESS(ADDR), .DATA(WDATA), .START_DELAY(0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .axi_master_port(axi0),
      .done_o(done0), .error_o(err0), .rdata_o(rdata0)
   );

   // Second instance only checks start timing; its slave never responds.
   assign axi0.aw_ready = 1'b0;
   assign axi0.w_ready  = 1'b0;
   assign axi0.b_id     = '0;
   assign axi0.b_resp   = '0;
   assign axi0.b_user   = '0;
   assign axi0.b_valid  = 1'b0;
   assign axi0.ar_ready = 1'b0;
   assign axi0.r_id     = '0;
   assign axi0.r_data   = '0;
   assign axi0.r_resp   = '0;
   assign axi0.r_last   = 1'b0;
   assign axi0.r_user   = '0;
   assign axi0.r_valid  = 1'b0;

   int n_chk = 0, n_pass = 0;
   exp_t q[$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   // ---------------- slave model ----------------
   int          aw_dly = 0, w_dly = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic        cfg_rovr = 1'b0, cfg_rlast = 1'b1;
   logic [DW-1:0] cfg_rdata = '0;
   int          aw_cnt, w_cnt;
   logic        aw_got, w_got;
   logic [DW-1:0] mem;

   assign axi.aw_ready = axi.aw_valid && (aw_cnt >= aw_dly);
   assign axi.w_ready  = axi.w_valid && (w_cnt >= w_dly);
   assign axi.ar_ready = 1'b1;
   assign axi.b_id     = '0;
   assign axi.b_user   = '0;
   assign axi.b_resp   = cfg_bresp;
   assign axi.r_id     = '0;
   assign axi.r_user   = '0;

   wire aw_hs = axi.aw_valid && axi.aw_ready;
   wire w_hs  = axi.w_valid && axi.w_ready;

   always @(posedge clk) begin
      if (rst) begin
         aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         axi.b_valid <= 1'b0; axi.r_valid <= 1'b0;
         axi.r_data <= '0; axi.r_resp <= '0; axi.r_last <= 1'b0;
      end else begin
         if (aw_hs) aw_cnt <= 0; else if (axi.aw_valid) aw_cnt <= aw_cnt + 1;
         if (w_hs) w_cnt <= 0; else if (axi.w_valid) w_cnt <= w_cnt + 1;
         if (w_hs) mem <= axi.w_data;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            axi.b_valid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs) w_got <= 1'b1;
         end
         if (axi.b_valid && axi.b_ready) axi.b_valid <= 1'b0;
         if (axi.ar_valid && axi.ar_ready) begin
            axi.r_valid <= 1'b1;
            axi.r_data  <= cfg_rovr ? cfg_rdata : (w_hs ? axi.w_data : mem);
            axi.r_resp  <= cfg_rresp;
            axi.r_last  <= cfg_rlast;
         end else if (axi.r_valid && axi.r_ready) begin
            axi.r_valid <= 1'b0;
         end
      end
   end

   // ---------------- cycle counter ----------------
   int cyc = 0, rst_cyc = 0;
   always @(posedge clk) begin
      cyc++;
      if (rst) rst_cyc = cyc;
   end

   // ---------------- monitor ----------------
   logic p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
   logic p_bready = 1'b0, p_done = 1'b0;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata;
   logic aw_seen = 1'b0, w_seen = 1'b0;
   int   wr_cyc = 0;

   always @(negedge clk) begin
      if (!p_rst && !rst) begin
         if (p_awv && !p_awr) begin
            chk("aw_hold", 64'(axi.aw_valid), 64'(1));
            chk("aw_addr_stable", axi.aw_addr, p_addr);
         end
         if (p_wv && !p_wr) begin
            chk("w_hold", 64'(axi.w_valid), 64'(1));
            chk("w_data_stable", axi.w_data, p_wdata);
         end
         if (p_awv && p_awr) chk("aw_drop", 64'(axi.aw_valid), 64'(0));
         if (p_wv && p_wr)   chk("w_drop", 64'(axi.w_valid), 64'(0));
      end
      if (axi.aw_valid && !p_awv) begin
         wr_cyc = cyc; aw_seen = 1'b0; w_seen = 1'b0;
         if (q.size() > 0) chk("start_delay", 64'(cyc - rst_cyc), 64'(q[0].start));
      end
      if (aw_hs) begin
         aw_seen = 1'b1;
         chk("aw_fields", {axi.aw_addr[31:0], 8'(axi.aw_id), axi.aw_len, 5'(axi.aw_size), 3'(axi.aw_burst)},
             {ADDR[31:0], 8'd0, 8'd0, 5'd3, 3'd1});
      end
      if (w_hs) begin
         w_seen = 1'b1;
         chk("w_fields", {axi.w_data[47:0], axi.w_strb, 7'd0, axi.w_last},
             {WDATA[47:0], 8'hFF, 7'd0, 1'b1});
      end
      if (axi.b_ready && !p_bready)
         chk("wresp_after_both", 64'(aw_seen && w_seen), 64'(1));
      if (done && !p_done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", 64'(cyc - wr_cyc), 64'(e.lat));
            chk("rdata", rdata, e.rdata);
            chk("error", 64'(err), 64'(e.err));
            chk("idle_at_done", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'(0));
         end
      end
      p_rst = rst; p_awv = axi.aw_valid; p_awr = axi.aw_ready; p_wv = axi.w_valid; p_wr = axi.w_ready;
      p_addr = axi.aw_addr; p_wdata = axi.w_data; p_bready = axi.b_ready; p_done = done;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 200 && !done; i++) tick();
      if (!done) chk("done_timeout", 64'(0), 64'(1));
      tick();
   endtask

   task automatic run(input int adly, input int wdly, input logic [1:0] bresp,
                      input logic rovr, input logic [63:0] rdat, input logic rlast,
                      input int lat, input logic [63:0] exp_rd, input logic exp_err);
      exp_t e;
      rst = 1'b1;
      aw_dly = adly; w_dly = wdly; cfg_bresp = bresp;
      cfg_rovr = rovr; cfg_rdata = rdat; cfg_rlast = rlast; cfg_rresp = 2'b00;
      e.lat = lat; e.rdata = exp_rd; e.err = exp_err; e.start = SD + 1;
      q.push_back(e);
      tick();
      rst = 1'b0;
      wait_done();
   endtask

   initial begin
      exp_t e;
      int i;
      rst = 1'b1;
      tick(); tick();
      chk("rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_error", 64'(err), 64'(0));
      chk("rst_rdata", rdata, 64'(0));
      chk("sd0_rst_aw", 64'(axi0.aw_valid), 64'(0));

      // zero-wait baseline; also START_DELAY=0 instance starts immediately
      e.lat = 4; e.rdata = 64'hABCD; e.err = 1'b0; e.start = SD + 1;
      q.push_back(e);
      rst = 1'b0;
      tick();
      chk("sd0_aw_first", 64'(axi0.aw_valid), 64'(1));
      chk("sd10_aw_idle", 64'(axi.aw_valid), 64'(0));
      wait_done();

      run(5, 2, 2'b00, 1'b0, 64'h0,    1'b1, 9, 64'hABCD, 1'b0); // stalled AW/W
      run(0, 0, 2'b10, 1'b0, 64'h0,    1'b1, 4, 64'hABCD, 1'b1); // SLVERR on B
      run(0, 0, 2'b00, 1'b1, 64'h1234, 1'b1, 4, 64'h1234, 1'b1); // wrong read data
      run(0, 0, 2'b00, 1'b0, 64'h0,    1'b0, 4, 64'hABCD, 1'b1); // missing r_last

      // reset while AW is stalled, then a clean rerun
      rst = 1'b1; aw_dly = 1000; w_dly = 0; cfg_bresp = 2'b00; cfg_rovr = 1'b0; cfg_rlast = 1'b1;
      tick();
      rst = 1'b0;
      for (i = 0; i < 100 && !axi.aw_valid; i++) tick();
      chk("mid_aw_started", 64'(axi.aw_valid), 64'(1));
      tick(); tick(); tick();
      chk("mid_aw_waiting", 64'(axi.aw_valid), 64'(1));
      e.lat = 4; e.rdata = 64'hABCD; e.err = 1'b0; e.start = SD + 1;
      q.push_back(e);
      rst = 1'b1;
      tick();
      rst = 1'b0; aw_dly = 0;
      chk("mid_rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'(0));
      chk("mid_rst_flags", 64'({done, err}), 64'(0));
      wait_done();

      chk("queue_empty", 64'(q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
